// File: rtl/sync_wconv_fifo.sv
// Synchronous width-converting FIFO: stores wide write words and hands them
// out as RATIO narrower sub-words, either registered (FWFT=0) or
// first-word-fall-through (FWFT=1).
module sync_wconv_fifo #(
    parameter int WR_DATA_WIDTH    = 32,
    parameter int RATIO            = 4,
    parameter int WR_DEPTH_WIDTH   = 6,
    parameter int ALMOST_FULL_NUM  = 60,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int FWFT             = 0,
    parameter int LSB_FIRST        = 1,
    localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH / RATIO,
    localparam int RD_DEPTH_WIDTH  = WR_DEPTH_WIDTH + $clog2(RATIO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int DEPTH = 1 << WR_DEPTH_WIDTH;
    // Sub-word index needs at least one bit even when RATIO is 1.
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WL_W  = WR_DEPTH_WIDTH + 1;
    localparam int RL_W  = RD_DEPTH_WIDTH + 1;

    logic [WR_DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [WR_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WR_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WL_W-1:0]           wr_lvl_q, wr_lvl_d;
    logic [RL_W-1:0]           rd_lvl_q, rd_lvl_d;
    logic [RD_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      ovf_q, ovf_d;
    logic                      udf_q, udf_d;

    logic                      wr_acc, rd_acc, last_sub, mem_we;
    logic [IDX_W-1:0]          sel;
    logic [RD_DATA_WIDTH-1:0]  head_sub;

    // Status flags come straight off the registered counts.
    assign wr_full        = (wr_lvl_q == WL_W'(DEPTH));
    assign rd_empty       = (rd_lvl_q == '0);
    assign wr_water_level = wr_lvl_q;
    assign rd_water_level = rd_lvl_q;
    assign almost_full    = (int'(wr_lvl_q) >= ALMOST_FULL_NUM);
    assign almost_empty   = (int'(rd_lvl_q) <= ALMOST_EMPTY_NUM);
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

    // Acceptance is judged only on pre-edge flags, so a same-cycle read never
    // makes room for a write and a same-cycle write never feeds a read.
    assign wr_acc   = wr_en & ~wr_full;
    assign rd_acc   = rd_en & ~rd_empty;
    assign last_sub = (idx_q == IDX_W'(RATIO - 1));
    assign mem_we   = wr_acc & ~flush & ~rst;

    // In FWFT mode the head sub-word is shown directly; zero while empty.
    assign rd_valid = (FWFT != 0) ? ~rd_empty : rd_valid_q;
    assign rd_data  = (FWFT != 0) ? (rd_empty ? '0 : head_sub) : rd_data_q;

    // Pick the current sub-word of the head slot in the configured order.
    always_comb begin
        sel      = (LSB_FIRST != 0) ? idx_q : IDX_W'(RATIO - 1) - idx_q;
        head_sub = RD_DATA_WIDTH'(mem_q[rd_ptr_q] >> (RD_DATA_WIDTH * int'(sel)));
    end

    // Next-state for pointers, levels, read register and sticky error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        wr_lvl_d   = wr_lvl_q;
        rd_lvl_d   = rd_lvl_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            idx_d    = '0;
            wr_lvl_d = '0;
            rd_lvl_d = '0;
        end else begin
            if (wr_en && wr_full)  ovf_d = 1'b1;
            if (rd_en && rd_empty) udf_d = 1'b1;
            if (wr_acc) wr_ptr_d = wr_ptr_q + WR_DEPTH_WIDTH'(1);
            if (rd_acc) begin
                rd_data_d  = head_sub;
                rd_valid_d = 1'b1;
                if (last_sub) begin
                    rd_ptr_d = rd_ptr_q + WR_DEPTH_WIDTH'(1);
                    idx_d    = '0;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                end
            end
            // A slot is released only once its last sub-word is consumed.
            wr_lvl_d = wr_lvl_q + WL_W'(wr_acc) - WL_W'(rd_acc & last_sub);
            rd_lvl_d = rd_lvl_q + (wr_acc ? RL_W'(RATIO) : RL_W'(0)) - RL_W'(rd_acc);
        end
    end

    // Storage array: never reset, written only by accepted writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            wr_lvl_q   <= '0;
            rd_lvl_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            wr_lvl_q   <= wr_lvl_d;
            rd_lvl_q   <= rd_lvl_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

endmodule

// File: tb/tb_sync_wconv_fifo.sv
// Directed bench: a vector table for the default FIFO plus hand-written
// sequences for fill/overflow, full read+write, flush and FWFT ordering.
module tb_sync_wconv_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (FWFT=0, LSB_FIRST=1)
    logic        rst, flush, wr_en, rd_en;
    logic [31:0] wr_data;
    logic        wr_full, almost_full, rd_valid, rd_empty, almost_empty, overflow, underflow;
    logic [6:0]  wr_lvl;
    logic [8:0]  rd_lvl;
    logic [7:0]  rd_data;

    sync_wconv_fifo dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(wr_full), .wr_water_level(wr_lvl), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
        .rd_water_level(rd_lvl), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    // FWFT, MSB-first instance
    logic        f_rst, f_flush, f_wr_en, f_rd_en;
    logic [31:0] f_wr_data;
    logic        f_wr_full, f_almost_full, f_rd_valid, f_rd_empty, f_almost_empty, f_overflow, f_underflow;
    logic [6:0]  f_wr_lvl;
    logic [8:0]  f_rd_lvl;
    logic [7:0]  f_rd_data;

    sync_wconv_fifo #(.FWFT(1), .LSB_FIRST(0)) dut_f (
        .clk(clk), .rst(f_rst), .flush(f_flush), .wr_data(f_wr_data), .wr_en(f_wr_en),
        .wr_full(f_wr_full), .wr_water_level(f_wr_lvl), .almost_full(f_almost_full),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
        .rd_water_level(f_rd_lvl), .almost_empty(f_almost_empty),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    endtask

    typedef struct {
        logic        rst, flush, wr_en, rd_en;
        logic [31:0] wdata;
        logic [7:0]  e_data;
        logic        e_valid, e_empty, e_full, e_af, e_ae, e_ovf, e_udf;
        logic [6:0]  e_wl;
        logic [8:0]  e_rl;
    } vec_t;

    localparam int NV = 18;
    vec_t v [NV];

    task automatic setv(input int i, input logic r, f, w, rd, input logic [31:0] wd,
                        input logic [7:0] d, input logic vl, em, fu, af, ae, ov, ud,
                        input logic [6:0] wl, input logic [8:0] rl);
        v[i].rst = r; v[i].flush = f; v[i].wr_en = w; v[i].rd_en = rd; v[i].wdata = wd;
        v[i].e_data = d; v[i].e_valid = vl; v[i].e_empty = em; v[i].e_full = fu;
        v[i].e_af = af; v[i].e_ae = ae; v[i].e_ovf = ov; v[i].e_udf = ud;
        v[i].e_wl = wl; v[i].e_rl = rl;
    endtask

    initial begin
        idle();
        f_rst = 1; f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;

        //      rst fl wr rd wdata         data  vl em fu af ae ov ud  wl  rl
        setv( 0, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        setv( 1, 1, 0, 1, 1, 32'h12345678, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        setv( 2, 0, 0, 0, 1, 32'h0,        8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        setv( 3, 0, 0, 1, 0, 32'h44332211, 8'h00, 0, 0, 0, 0, 1, 0, 1, 1, 4);
        setv( 4, 0, 0, 0, 1, 32'h0,        8'h11, 1, 0, 0, 0, 1, 0, 1, 1, 3);
        setv( 5, 0, 0, 0, 1, 32'h0,        8'h22, 1, 0, 0, 0, 1, 0, 1, 1, 2);
        setv( 6, 0, 0, 0, 1, 32'h0,        8'h33, 1, 0, 0, 0, 1, 0, 1, 1, 1);
        setv( 7, 0, 0, 0, 1, 32'h0,        8'h44, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        setv( 8, 0, 0, 0, 0, 32'h0,        8'h44, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        // write into empty with rd_en: read is rejected
        setv( 9, 0, 0, 1, 1, 32'hA1B2C3D4, 8'h44, 0, 0, 0, 0, 1, 0, 1, 1, 4);
        setv(10, 0, 0, 1, 1, 32'h01020304, 8'hD4, 1, 0, 0, 0, 0, 0, 1, 2, 7);
        setv(11, 0, 0, 0, 1, 32'h0,        8'hC3, 1, 0, 0, 0, 0, 0, 1, 2, 6);
        // flush ignores the concurrent write, keeps rd_data and flags
        setv(12, 0, 1, 1, 1, 32'hFFFFFFFF, 8'hC3, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        setv(13, 0, 0, 1, 0, 32'h55667788, 8'hC3, 0, 0, 0, 0, 1, 0, 1, 1, 4);
        setv(14, 0, 0, 0, 1, 32'h0,        8'h88, 1, 0, 0, 0, 1, 0, 1, 1, 3);
        // reset mid-stream discards data and clears everything visible
        setv(15, 1, 0, 1, 1, 32'h0,        8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        setv(16, 0, 0, 1, 0, 32'h99AABBCC, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 4);
        setv(17, 0, 0, 0, 1, 32'h0,        8'hCC, 1, 0, 0, 0, 1, 0, 0, 1, 3);

        for (int i = 0; i < NV; i++) begin
            rst = v[i].rst; flush = v[i].flush; wr_en = v[i].wr_en; rd_en = v[i].rd_en;
            wr_data = v[i].wdata;
            step();
            chk($sformatf("v%0d rd_data", i),  32'(rd_data),      32'(v[i].e_data));
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid),     32'(v[i].e_valid));
            chk($sformatf("v%0d rd_empty", i), 32'(rd_empty),     32'(v[i].e_empty));
            chk($sformatf("v%0d wr_full", i),  32'(wr_full),      32'(v[i].e_full));
            chk($sformatf("v%0d almost_full", i),  32'(almost_full),  32'(v[i].e_af));
            chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(v[i].e_ae));
            chk($sformatf("v%0d overflow", i),  32'(overflow),    32'(v[i].e_ovf));
            chk($sformatf("v%0d underflow", i), 32'(underflow),   32'(v[i].e_udf));
            chk($sformatf("v%0d wr_lvl", i),   32'(wr_lvl),       32'(v[i].e_wl));
            chk($sformatf("v%0d rd_lvl", i),   32'(rd_lvl),       32'(v[i].e_rl));
        end

        // ---- fill: 65 back-to-back writes, data 0x10203040+i ----
        idle(); rst = 1; step(); step(); idle();
        for (int i = 0; i < 65; i++) begin
            wr_en = 1; wr_data = 32'h10203040 + 32'(i);
            step();
            if (i == 58) chk("af before 60th", 32'(almost_full), 32'd0);
            if (i == 59) chk("af after 60th",  32'(almost_full), 32'd1);
            if (i == 62) chk("full before 64th", 32'(wr_full), 32'd0);
            if (i == 63) begin
                chk("full after 64th", 32'(wr_full), 32'd1);
                chk("ovf after 64th", 32'(overflow), 32'd0);
            end
        end
        idle();
        chk("fill overflow", 32'(overflow), 32'd1);
        chk("fill wr_lvl", 32'(wr_lvl), 32'd64);
        chk("fill rd_lvl", 32'(rd_lvl), 32'd256);
        chk("fill full",   32'(wr_full), 32'd1);

        // ---- head index 3 on a full FIFO, then write+read together ----
        rd_en = 1; step(); chk("hd sub0", 32'(rd_data), 32'h40);
        step(); chk("hd sub1", 32'(rd_data), 32'h30);
        step(); chk("hd sub2", 32'(rd_data), 32'h20);
        chk("hd rd_lvl 253", 32'(rd_lvl), 32'd253);
        chk("hd still full", 32'(wr_full), 32'd1);
        wr_en = 1; wr_data = 32'hDEADBEEF; step(); idle();
        chk("rw sub3", 32'(rd_data), 32'h10);
        chk("rw wr_lvl", 32'(wr_lvl), 32'd63);
        chk("rw rd_lvl", 32'(rd_lvl), 32'd252);
        chk("rw full clr", 32'(wr_full), 32'd0);
        chk("rw overflow", 32'(overflow), 32'd1);
        rd_en = 1; step(); idle();
        chk("next word sub0", 32'(rd_data), 32'h41);

        // ---- flush after 10 writes, 3 reads, with underflow set ----
        rst = 1; step(); idle();
        rd_en = 1; step(); idle();
        chk("pre-flush udf", 32'(underflow), 32'd1);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; wr_data = 32'h0A0B0C00 + 32'(i); step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin rd_en = 1; step(); end
        idle();
        chk("pre-flush rd_lvl", 32'(rd_lvl), 32'd37);
        chk("pre-flush data", 32'(rd_data), 32'h0B);
        flush = 1; step(); idle();
        chk("flush wr_lvl", 32'(wr_lvl), 32'd0);
        chk("flush rd_lvl", 32'(rd_lvl), 32'd0);
        chk("flush empty",  32'(rd_empty), 32'd1);
        chk("flush udf kept", 32'(underflow), 32'd1);
        chk("flush ovf kept", 32'(overflow), 32'd0);
        chk("flush data kept", 32'(rd_data), 32'h0B);
        wr_en = 1; wr_data = 32'hCAFEF00D; step(); idle();
        rd_en = 1; step(); idle();
        chk("post-flush sub0", 32'(rd_data), 32'h0D);

        // ---- FWFT, MSB-first ----
        f_rst = 1; step(); f_rst = 0;
        chk("f rst empty", 32'(f_rd_empty), 32'd1);
        chk("f rst valid", 32'(f_rd_valid), 32'd0);
        f_wr_en = 1; f_wr_data = 32'hAABBCCDD; step(); f_wr_en = 0;
        chk("f head", 32'(f_rd_data), 32'hAA);
        chk("f empty0", 32'(f_rd_empty), 32'd0);
        chk("f valid1", 32'(f_rd_valid), 32'd1);
        f_rd_en = 1; step(); chk("f sub1", 32'(f_rd_data), 32'hBB);
        step(); chk("f sub2", 32'(f_rd_data), 32'hCC);
        step(); chk("f sub3", 32'(f_rd_data), 32'hDD);
        step(); f_rd_en = 0;
        chk("f drained empty", 32'(f_rd_empty), 32'd1);
        chk("f drained valid", 32'(f_rd_valid), 32'd0);
        chk("f no udf", 32'(f_underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sync_wconv_fifo.md
SYNC_WCONV_FIFO -- requirements
Module: sync_wconv_fifo

Interface
REQ-001: Parameter WR_DATA_WIDTH, default 32, write word width in bits.
REQ-002: Parameter RATIO, default 4, write-to-read width ratio; legal values 1, 2, 4, 8; RD_DATA_WIDTH = WR_DATA_WIDTH/RATIO.
REQ-003: Parameter WR_DEPTH_WIDTH, default 6, storage = 2**WR_DEPTH_WIDTH write words; RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + log2(RATIO).
REQ-004: Parameter ALMOST_FULL_NUM, default 60, almost_full threshold in write words.
REQ-005: Parameter ALMOST_EMPTY_NUM, default 4, almost_empty threshold in read words.
REQ-006: Parameter FWFT, default 0; 1 = first-word-fall-through read mode.
REQ-007: Parameter LSB_FIRST, default 1; 1 = least-significant sub-word read first, 0 = most-significant first.
REQ-008: One clock; reset is synchronous and active-high: clk  input  1  sole clock, all state updates on rising edge.
REQ-009: rst  input  1  synchronous active-high reset.
REQ-010: flush  input  1  synchronous clear of contents, lower priority than rst.
REQ-011: wr_data  input  WR_DATA_WIDTH  write word.
REQ-012: wr_en  input  1  write request.
REQ-013: wr_full  output  1  no free write-word slot.
REQ-014: wr_water_level  output  WR_DEPTH_WIDTH+1  occupied write-word slots.
REQ-015: almost_full  output  1  wr_water_level >= ALMOST_FULL_NUM.
REQ-016: rd_en  input  1  read request (FWFT=1: acknowledge of presented sub-word).
REQ-017: rd_data  output  RD_DATA_WIDTH  read sub-word.
REQ-018: rd_valid  output  1  FWFT=0: one-cycle pulse, rd_data updated; FWFT=1: equals ~rd_empty.
REQ-019: rd_empty  output  1  no unread sub-word.
REQ-020: rd_water_level  output  RD_DEPTH_WIDTH+1  unread sub-words.
REQ-021: almost_empty  output  1  rd_water_level <= ALMOST_EMPTY_NUM.
REQ-022: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-023: Write accepted at edge iff wr_en=1 and wr_full=1'b0 before the edge; word stored at write pointer, pointer wraps modulo 2**WR_DEPTH_WIDTH.
REQ-024: Read accepted at edge iff rd_en=1 and rd_empty=1'b0 before the edge; sub-word index advances, head slot freed after its RATIO-th sub-word.
REQ-025: Sub-word k (k=0 first) = wr_data bits [k*RD+:RD] if LSB_FIRST=1, else bits [(RATIO-1-k)*RD+:RD].
REQ-026: wr_water_level = slots holding >=1 unread sub-word; rd_water_level = wr_water_level*RATIO - sub-word index; both registered, updated same edge as accepted op.
REQ-027: wr_full = (wr_water_level == 2**WR_DEPTH_WIDTH); rd_empty = (rd_water_level == 0); flags derived from registered counts, no extra latency.
REQ-028: Simultaneous accepted write and read: both occur; write while full rejected even if same-cycle read frees a slot; read while empty rejected even if same-cycle write.
REQ-029: Latency: write accepted at edge N -> rd_empty=0 after edge N.
REQ-030: FWFT=0: read accepted at edge N -> rd_data and rd_valid=1 after edge N; rd_data holds until next accepted read; rd_valid=0 otherwise.
REQ-031: FWFT=1: rd_data presents head sub-word whenever rd_empty=0; rd_en advances to next sub-word.
REQ-032: Rejected write sets overflow; rejected read sets underflow; rejected ops change no other state; flags clear only on rst.
REQ-033: flush: pointers, index, levels cleared; rd_valid=0; rd_data, overflow, underflow retained; concurrent wr_en/rd_en ignored.

Reset
REQ-034: rst=1 at edge: wr_full=0, rd_empty=1, levels=0, almost_full=0, almost_empty=1, rd_data=0, rd_valid=0, overflow=0, underflow=0; pointers and index 0; wr_en/rd_en ignored; storage contents not cleared.
REQ-035: rst mid-burst discards all data; first write after rst release read back first.

Verification
REQ-036: rst 2 cycles -> all outputs at REQ-034 values; rd_en=1 afterwards -> underflow=1, rd_valid=0, rd_data=0.
REQ-037: Defaults, write 0x44332211, then rd_en 4 cycles -> rd_data 0x11,0x22,0x33,0x44 with rd_valid=1 each; rd_water_level 4,3,2,1,0; rd_empty=1 after 4th.
REQ-038: 65 back-to-back writes -> almost_full after 60th, wr_full after 64th, 65th rejected, overflow=1, wr_water_level=64, rd_water_level=256.
REQ-039: Full FIFO, head index 3, wr_en=1 and rd_en=1 same cycle -> write rejected, overflow=1, wr_water_level 64->63, rd_water_level 253->252.
REQ-040: FWFT=1, LSB_FIRST=0, write 0xAABBCCDD -> after that edge rd_data=0xAA, rd_empty=0, rd_valid=1; rd_en 4 cycles -> 0xBB,0xCC,0xDD then rd_empty=1.
REQ-041: 10 writes, 3 reads, flush -> levels=0, rd_empty=1, overflow/underflow unchanged; next write/read returns new data's sub-word 0.
